// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Word-organised synchronous data RAM behind a req/ready
//               handshake. A wait-state counter stretches each access.
//               Requests are serialised as IDLE -> WAIT -> DONE.
//               Optional macro DMEM_ALIGN_CHECK_EN: flag misaligned
//               accesses and suppress their effect on the RAM and on rdata.
// Revision    : 1.0  initial release
// ============================================================================
module dmem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_LSB    = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_req,
  input  logic        dmem_write_en,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_busy,
  output logic        dmem_misalign
);

  localparam int c_iw = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [c_iw-1:0]   r_idx;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic              r_mis_req;
  logic [31:0]       r_rdata;
  logic              r_ready;
  logic              r_busy;
  logic              r_mis;
  logic [31:0]       r_mem [DEPTH];

  logic              w_accept;
  logic              w_access;
  logic              w_write;
  logic              w_load;
  logic              w_mis_in;
  logic [c_iw-1:0]   w_idx_in;
  logic [31:0]       w_unused_addr;

  // Upper address bits are deliberately ignored (addresses alias modulo DEPTH)
  assign w_idx_in      = dmem_addr[ADDR_LSB +: c_iw];
  assign w_unused_addr = dmem_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic [31:0] c_lsb_mask = 32'((64'd1 << ADDR_LSB) - 64'd1);
  assign w_mis_in = |(dmem_addr & c_lsb_mask);
`else
  // Low byte-offset bits are dropped; a misaligned access hits the truncated word
  assign w_mis_in = 1'b0;
`endif

  // Next-state logic; the access edge is the WAIT cycle with the counter at zero
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_access = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dmem_req) begin
          w_accept = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A reset on the access edge must cancel a pending store, hence rst_n here
  assign w_write = w_access &&  r_we && !r_mis_req && rst_n;
  assign w_load  = w_access && !r_we && !r_mis_req;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Request latch, wait counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_we      <= 1'b0;
      r_wdata   <= 32'd0;
      r_mis_req <= 1'b0;
      r_rdata   <= 32'd0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_mis     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_mis   <= 1'b0;
      if (w_accept) begin
        r_idx     <= w_idx_in;
        r_we      <= dmem_write_en;
        r_wdata   <= dmem_wdata;
        r_mis_req <= w_mis_in;
        r_cnt     <= 4'(WAIT_CYCLES);
        r_busy    <= 1'b1;
      end
      if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_ready <= 1'b1;
        r_busy  <= 1'b0;
        r_mis   <= r_mis_req;
      end
      if (w_load) begin
        r_rdata <= r_mem[r_idx];
      end
    end
  end

  // RAM write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_idx] <= r_wdata;
  end

  assign dmem_rdata    = r_rdata;
  assign dmem_ready    = r_ready;
  assign dmem_busy     = r_busy;
  assign dmem_misalign = r_mis;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Self-checking bench for dmem_ctrl. A word-array reference
//               model predicts load data, latency and the misalign flag.
//               Build with DMEM_ALIGN_CHECK_EN to exercise the alignment check.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_ctrl;

  localparam int c_depth = 16;
  localparam int c_wc    = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit c_align = 1'b1;
`else
  localparam bit c_align = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_req;
  logic        dmem_write_en;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_busy;
  logic        dmem_misalign;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_mem [c_depth];
  logic [31:0] m_rdata;

  dmem_ctrl #(
    .DEPTH       (c_depth),
    .ADDR_LSB    (2),
    .WAIT_CYCLES (c_wc)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dmem_req      (dmem_req),
    .dmem_write_en (dmem_write_en),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ready    (dmem_ready),
    .dmem_busy     (dmem_busy),
    .dmem_misalign (dmem_misalign)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; called at a negedge, returns at a negedge in IDLE
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    logic mis;
    int   idx;
    int   k;
    bit   seen;
    mis = c_align && (addr[1:0] != 2'b00);
    idx = int'((addr >> 2) % c_depth);
    dmem_req      = 1'b1;
    dmem_write_en = we;
    dmem_addr     = addr;
    dmem_wdata    = wd;
    @(posedge clk);
    @(negedge clk);
    k    = 1;
    seen = 1'b0;
    while (!seen && k < 40) begin
      if (dmem_ready) begin
        seen = 1'b1;
      end else begin
        check("busy_wait", {31'd0, dmem_busy}, 32'd1);
        dmem_addr     = $urandom;
        dmem_wdata    = $urandom;
        dmem_write_en = 1'($urandom_range(1));
        @(negedge clk);
        k++;
      end
    end
    if (!seen) begin
      check("timeout", 32'd0, 32'd1);
    end else begin
      if (!mis) begin
        if (we) m_mem[idx] = wd;
        else    m_rdata    = m_mem[idx];
      end
      check("latency", 32'(k), 32'(c_wc + 2));
      check("busy_at_ready", {31'd0, dmem_busy}, 32'd0);
      check("rdata", dmem_rdata, m_rdata);
      check("misalign", {31'd0, dmem_misalign}, {31'd0, mis});
    end
    dmem_req = 1'b0;
    @(negedge clk);
    check("ready_pulse", {31'd0, dmem_ready}, 32'd0);
    check("rdata_hold", dmem_rdata, m_rdata);
  endtask

  initial begin
    logic [31:0] a;
    rst_n         = 1'b0;
    dmem_req      = 1'b1;
    dmem_write_en = 1'b1;
    dmem_addr     = 32'h0;
    dmem_wdata    = 32'h0BAD_F00D;
    m_rdata       = 32'd0;

    // Reset held for 3 edges with a request pending
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", {31'd0, dmem_ready}, 32'd0);
      check("rst_busy", {31'd0, dmem_busy}, 32'd0);
      check("rst_rdata", dmem_rdata, 32'd0);
      check("rst_mis", {31'd0, dmem_misalign}, 32'd0);
    end
    rst_n = 1'b1;
    // First accept happens on the first edge with rst_n high
    access(1'b1, 32'h0, 32'h0BAD_F00D);

    // Fill every word so the model knows all contents
    for (int i = 1; i < c_depth; i++) access(1'b1, 32'(i * 4), $urandom);

    // Store then load
    access(1'b1, 32'h40, 32'hDEAD_BEEF);
    access(1'b0, 32'h40, 32'h0);
    check("dir_load", dmem_rdata, 32'hDEAD_BEEF);

    // Aliasing modulo 16 words
    access(1'b1, 32'h00, 32'h1111_1111);
    access(1'b1, 32'h40, 32'h2222_2222);
    access(1'b0, 32'h00, 32'h0);
    check("alias", dmem_rdata, 32'h2222_2222);

    // Input hold (the task scrambles inputs during WAIT)
    access(1'b1, 32'h10, 32'hA5A5_A5A5);
    access(1'b0, 32'h10, 32'h0);
    check("hold", dmem_rdata, 32'hA5A5_A5A5);
    access(1'b0, 32'h20, 32'h0);

    // Reset in the middle of a pending store
    access(1'b1, 32'h8, 32'hCAFE_F00D);
    dmem_req      = 1'b1;
    dmem_write_en = 1'b1;
    dmem_addr     = 32'h8;
    dmem_wdata    = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    dmem_req = 1'b0;
    check("mid_busy", {31'd0, dmem_busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    m_rdata = 32'd0;
    check("mid_rst_busy", {31'd0, dmem_busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("mid_rst_ready", {31'd0, dmem_ready}, 32'd0);
      @(negedge clk);
    end
    access(1'b0, 32'h8, 32'h0);
    check("mid_rst_keep", dmem_rdata, 32'hCAFE_F00D);

    // Misaligned store, then read the word it would have hit
    access(1'b1, 32'h42, 32'h55);
    access(1'b0, 32'h40, 32'h0);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      access(1'($urandom_range(1)), a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Ready and busy must never overlap
  always @(negedge clk) begin
    if (rst_n && dmem_ready) check("ready_busy_excl", {31'd0, dmem_busy}, 32'd0);
  end

endmodule
`default_nettype wire
